// File: rtl/imem_loader.sv
// Program loader: assembles a header-prefixed little-endian byte stream into
// instruction words, writes them from address 0 and holds the CPU in reset until done.
module imem_loader #(
  parameter int XLEN    = 32,
  parameter int PC_BITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_byte,
  output logic               in_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [PC_BITS-1:0] imem_waddr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic               cpu_rst,
  output logic               done,
  output logic               err
);

  localparam int BPW   = XLEN / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int DEPTH = 1 << PC_BITS;

  localparam logic [8:0]       DEPTH_W  = 9'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  localparam logic [2:0] ST_HDR   = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [PC_BITS-1:0] addr_q, addr_d;
  logic [XLEN-1:0]    asm_q, asm_d;
  logic               we_q, we_d;
  logic [PC_BITS-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               xfer_s;
  logic [8:0]         hdr_n_s;
  logic [XLEN-1:0]    word_s;

  // Ready depends on state alone so there is no path from in_valid to in_ready.
  always_comb begin
    case (state_q)
      ST_HDR, ST_DATA: in_ready = 1'b1;
      default:         in_ready = 1'b0;
    endcase
  end

  assign xfer_s  = in_valid && in_ready;
  assign hdr_n_s = {1'b0, in_byte};

  // Assembly word with the incoming byte dropped into the lane selected by idx_q.
  always_comb begin
    word_s = asm_q;
    for (int b = 0; b < BPW; b++) begin
      if (idx_q == IDX_W'(b)) begin
        word_s[8*b +: 8] = in_byte;
      end else begin
        word_s[8*b +: 8] = asm_q[8*b +: 8];
      end
    end
  end

  // Loader next-state and output-register logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    asm_d     = asm_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    case (state_q)
      ST_HDR: begin
        if (xfer_s) begin
          if ((hdr_n_s == 9'd0) || (hdr_n_s > DEPTH_W)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            cnt_d   = hdr_n_s;
            idx_d   = '0;
            addr_d  = '0;
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          asm_d = word_s;
          if (idx_q == LAST_IDX) begin
            // Registering the write here makes imem_we high exactly during WRITE.
            state_d = ST_WRITE;
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = word_s;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WRITE: begin
        cnt_d  = cnt_q - 9'd1;
        addr_d = addr_q + PC_BITS'(1);
        idx_d  = '0;
        if (cnt_q == 9'd1) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE, ST_ERR: begin
        if (reload) begin
          state_d   = ST_HDR;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          addr_d    = '0;
          idx_d     = '0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d   = ST_HDR;
        cpu_rst_d = 1'b1;
        done_d    = 1'b0;
        err_d     = 1'b0;
        addr_d    = '0;
        idx_d     = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HDR;
      idx_q     <= '0;
      cnt_q     <= 9'd0;
      addr_q    <= '0;
      asm_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      asm_q     <= asm_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header/data streaming, error headers,
// reload handling, in_valid gaps and asynchronous reset mid-load.
module tb_imem_loader;
  localparam int XLEN    = 32;
  localparam int PC_BITS = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [7:0]         in_byte;
  logic               in_ready;
  logic               reload;
  logic               imem_we;
  logic [PC_BITS-1:0] imem_waddr;
  logic [XLEN-1:0]    imem_wdata;
  logic               cpu_rst;
  logic               done;
  logic               err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [PC_BITS-1:0] wa_q[$];
  logic [XLEN-1:0]    wd_q[$];
  logic [31:0]        img[$];

  imem_loader #(.XLEN(XLEN), .PC_BITS(PC_BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Capture every write pulse mid-cycle; the loader must not be ready while writing.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa_q.push_back(imem_waddr);
      wd_q.push_back(imem_wdata);
      chk("in_ready_in_write", in_ready, 64'd0);
    end
  end

  task automatic send(input logic [7:0] b, input int gaps);
    int t;
    for (int g = 0; g < gaps; g++) begin
      @(negedge clk); in_valid = 1'b0; in_byte = 8'hA5;
    end
    @(negedge clk); in_valid = 1'b1; in_byte = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk); t++;
    end
    if (in_ready !== 1'b1) chk("ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk); in_valid = 1'b0; in_byte = 8'h5A;
  endtask

  task automatic send_image(input logic [7:0] n, input bit gappy);
    logic [31:0] w;
    send(n, 0);
    for (int k = 0; k < img.size(); k++) begin
      w = img[k];
      for (int j = 0; j < 4; j++) send(w[8*j +: 8], gappy ? int'($urandom_range(0, 2)) : 0);
    end
    idle();
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 50) begin
      @(negedge clk); t++;
    end
    chk("done_reached", done, 64'd1);
    chk("cpu_rst_released", cpu_rst, 64'd0);
  endtask

  task automatic chk_writes();
    int n;
    chk("wr_count", wa_q.size(), img.size());
    n = (wa_q.size() < img.size()) ? wa_q.size() : img.size();
    for (int k = 0; k < n; k++) begin
      chk("waddr", wa_q[k], k);
      chk("wdata", wd_q[k], img[k]);
    end
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic chk_reset_vals();
    chk("rst_we", imem_we, 64'd0);
    chk("rst_waddr", imem_waddr, 64'd0);
    chk("rst_wdata", imem_wdata, 64'd0);
    chk("rst_cpu_rst", cpu_rst, 64'd1);
    chk("rst_done", done, 64'd0);
    chk("rst_err", err, 64'd0);
    chk("rst_in_ready", in_ready, 64'd1);
  endtask

  task automatic do_reload();
    @(negedge clk); in_valid = 1'b0; reload = 1'b1;
    @(posedge clk); #1; reload = 1'b0;
    chk("reload_cpu_rst", cpu_rst, 64'd1);
    chk("reload_done", done, 64'd0);
    chk("reload_err", err, 64'd0);
    chk("reload_ready", in_ready, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; reload = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    // Two-word image with continuous valid and exact write/done timing.
    send(8'h02, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    chk("w0_we", imem_we, 64'd1);
    chk("w0_ready", in_ready, 64'd0);
    send(8'h93, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
    chk("w1_we", imem_we, 64'd1);
    chk("w1_done_early", done, 64'd0);
    chk("w1_cpu_rst", cpu_rst, 64'd1);
    @(posedge clk); #1;
    chk("done_next", done, 64'd1);
    chk("cpu_rst_next", cpu_rst, 64'd0);
    chk("we_drop", imem_we, 64'd0);
    chk("done_ready", in_ready, 64'd0);
    idle();
    repeat (2) @(negedge clk);
    img = '{32'h0000_0013, 32'h0010_0093};
    chk_writes();

    // Zero header goes to ERR; reload recovers.
    do_reload();
    send(8'h00, 0);
    chk("hdr0_err", err, 64'd1);
    chk("hdr0_cpu_rst", cpu_rst, 64'd1);
    chk("hdr0_ready", in_ready, 64'd0);
    idle();
    repeat (4) @(negedge clk);
    chk("hdr0_no_writes", wa_q.size(), 64'd0);
    do_reload();
    img = '{32'hDEAD_BEEF};
    send_image(8'h01, 1'b0);
    wait_done();
    chk_writes();

    // Header above depth is rejected; full-depth image lands at 0..31.
    do_reload();
    send(8'h21, 0);
    chk("hdr33_err", err, 64'd1);
    idle();
    do_reload();
    img.delete();
    for (int k = 0; k < 32; k++) img.push_back(32'(k) * 32'h0403_0201 + 32'h0000_0093);
    send_image(8'h20, 1'b0);
    wait_done();
    chk("last_addr", (wa_q.size() == 32) ? 64'(wa_q[31]) : 64'hFFFF, 64'd31);
    chk_writes();

    // Three words with random idle gaps, then the same image gap-free.
    do_reload();
    img = '{32'h1122_3344, 32'hA5A5_0F0F, 32'hCAFE_BABE};
    send_image(8'h03, 1'b1);
    wait_done();
    chk_writes();
    do_reload();
    send_image(8'h03, 1'b0);
    wait_done();
    chk_writes();

    // Asynchronous reset part-way through a four-word load.
    do_reload();
    send(8'h04, 0);
    send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0);
    send(8'hEE, 0); send(8'hFF, 0);
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wa_q.delete(); wd_q.delete();
    img = '{32'h0BAD_F00D};
    send_image(8'h01, 1'b0);
    wait_done();
    chk_writes();

    // Reload during DATA is ignored.
    do_reload();
    send(8'h01, 0);
    send(8'h44, 0); send(8'h33, 0);
    reload = 1'b1;
    send(8'h22, 0);
    reload = 1'b0;
    chk("reload_in_data_ignored", cpu_rst, 64'd1);
    send(8'h11, 0);
    idle();
    wait_done();
    img = '{32'h1122_3344};
    chk_writes();

    // Reload in DONE: second image overwrites from address 0.
    do_reload();
    img = '{32'hAAAA_5555, 32'h0F1E_2D3C};
    send_image(8'h02, 1'b0);
    wait_done();
    chk_writes();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader: the write side of the CPU instruction memory, which the fetch stage only ever reads by PC.
- Accepts a byte stream over a valid/ready handshake (header byte, then little-endian instruction words) and writes each assembled word into instruction memory at consecutive addresses from 0.
- Holds the CPU in reset until the whole image is written.
- Sits between the host byte source (UART RX or testbench) and the instruction memory write port and CPU reset.

Parameters:
XLEN, 32, instruction word width; must be a multiple of 8; BPW = XLEN/8 bytes per word
PC_BITS, 5, instruction memory address width; DEPTH = 2^PC_BITS words

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  in_byte holds a valid byte
in_byte  input  8  stream byte
in_ready  output  1  loader can accept a byte this cycle
reload  input  1  single-cycle pulse: restart load; honoured only in DONE or ERR
imem_we  output  1  instruction memory write enable (one-cycle pulse per word)
imem_waddr  output  PC_BITS  write address
imem_wdata  output  XLEN  write data
cpu_rst  output  1  reset to CPU core; high until the load completes
done  output  1  image loaded; level
err  output  1  bad header; level

Behaviour:
- Reset is asynchronous and active-high, on port rst, clocked by clk.
- While rst is asserted: state=HDR, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_rst=1, done=0, err=0, byte index=0, word counter=0, in_ready=1.
- A byte transfer occurs on a rising edge with in_valid && in_ready. in_ready is decoded from state only (no combinational path from in_valid): 1 in HDR and DATA, 0 in WRITE, DONE and ERR. in_byte is ignored whenever no transfer occurs.
- State HDR:
  - On a transfer, the byte N is the word count.
  - N==0 or N>DEPTH -> ERR.
  - Otherwise latch N into the word counter, clear the byte index and address -> DATA.
- State DATA:
  - Each transfer places the byte into lane [8*i+7:8*i] of the assembly register, where i is the byte index. The first byte received is the least significant.
  - On the transfer with i==BPW-1 -> WRITE; otherwise i increments.
- State WRITE (exactly one cycle, in_ready=0):
  - Outputs are registered, so imem_we=1 in the cycle after the last byte of the word is accepted.
  - imem_waddr = current address; imem_wdata = assembled word.
  - Decrement the word counter. Increment the address; it wraps modulo DEPTH, but it never reaches the wrap because N<=DEPTH. Clear i.
  - If the counter was 1 -> DONE; else -> DATA.
  - imem_we returns to 0 in all other cycles; imem_waddr and imem_wdata hold their last values.
- State DONE: cpu_rst=0, done=1, registered and set on entry. The CPU leaves reset on the first edge after the final write.
- State ERR: err=1, cpu_rst stays 1. No instruction memory writes occur.
- reload pulse in DONE or ERR:
  - Next state is HDR; cpu_rst=1, done=0, err=0 on the next edge; address and i are cleared.
  - reload in HDR, DATA or WRITE is ignored.
- Memory contents from a partial or aborted load are not cleared.
- Asynchronous rst mid-load aborts immediately and returns everything to reset values. Words already written stay in memory.
- Arithmetic: the word counter is 9 bits, so DEPTH up to 256 is handled. The header compare is N > DEPTH, done at 9-bit width.
- Throughput: 1 byte per cycle in DATA. Each word costs BPW+1 cycles (the extra cycle is WRITE).

Test Plan:
- Reset then stream 0x02, 0x13,0x00,0x00,0x00, 0x93,0x00,0x10,0x00 with in_valid continuous:
  - imem_we pulses twice: addr 0 data 0x00000013, then addr 1 data 0x00100093.
  - in_ready=0 in each WRITE cycle.
  - done=1 and cpu_rst=0 one cycle after the second write.
- Header 0x00 -> err=1, cpu_rst=1, in_ready=0, no imem_we. Then a reload pulse -> err=0, in_ready=1, and a valid 1-word load then succeeds at addr 0.
- Header 0x21 (33 > DEPTH 32) -> ERR. Header 0x20 with 32 words -> last write at addr 31, then DONE.
- Random in_valid gaps (about 50% idle) during a 3-word load -> identical writes and addresses to the gap-free run; bytes with in_valid=0 are never captured.
- Assert rst after 2 bytes of word 1 of a 4-word load -> all outputs return to reset values immediately. A fresh 1-word load then writes addr 0.
- reload pulsed during DATA -> ignored, load completes normally. reload in DONE -> cpu_rst rises on the next edge and a second image overwrites from addr 0.
